bitrev_reorder: RTL and testbench

- Output reorder stage that sits after the last radix-2^2 SDF unit of the FFT pipeline.
- Receives the FFT result stream, which is in bit-reversed index order, and re-emits each N-point frame in natural order.
- Reads the same enable/real/imag stream protocol the SDF units write, and drives the same protocol downstream.
- Uses ping-pong buffering so back-to-back frames stream with no gaps.

---
 rtl/bitrev_reorder.sv | 122 ++++++++++++
 tb/tb_bitrev_reorder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_reorder.sv
// Output reorder stage for the SDF FFT pipeline: buffers each N-point frame in one of
// two banks at its bit-reversed address and streams it back out in natural order.
module bitrev_reorder #(
    parameter int N         = 64,
    parameter int WIDTH     = 16,
    parameter int BITREV_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i,
    output logic             frame_err
);

    localparam int LOG_N = $clog2(N);
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    logic [2*WIDTH-1:0] mem [0:2*N-1];

    logic [LOG_N-1:0] wr_count;
    logic             wr_bank;
    logic [LOG_N-1:0] wr_addr;
    logic             wr_last;
    logic             truncated;

    logic [LOG_N-1:0] rd_count;
    logic             rd_bank;
    rd_state_t        rd_state;
    logic             rd_go;
    logic             rd_last;

    logic [1:0]       full;
    logic [1:0]       full_nxt;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    assign wr_addr   = (BITREV_EN != 0) ? bitrev(wr_count) : wr_count;
    assign wr_last   = idata_en && (wr_count == LAST);
    assign truncated = !idata_en && (wr_count != '0);

    // A bank stays full from its last write until its last read is issued, so a
    // read can start the very cycle after the frame lands, without an FSM hop.
    assign rd_go   = (rd_state == READ) || full[rd_bank];
    assign rd_last = rd_go && (rd_count == LAST);

    always_comb begin
        full_nxt = full;
        if (rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (idata_en) begin
            mem[{wr_bank, wr_addr}] <= {idata_r, idata_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count  <= '0;
            wr_bank   <= 1'b0;
            frame_err <= 1'b0;
            full      <= 2'b00;
        end else begin
            full      <= full_nxt;
            frame_err <= truncated;
            if (idata_en) begin
                wr_count <= wr_count + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                wr_count <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state <= IDLE;
            rd_count <= '0;
            rd_bank  <= 1'b0;
            odata_en <= 1'b0;
            odata_r  <= '0;
            odata_i  <= '0;
        end else begin
            odata_en <= rd_go;
            if (rd_go) begin
                {odata_r, odata_i} <= mem[{rd_bank, rd_count}];
                rd_count <= rd_count + 1'b1;
                if (rd_last) begin
                    rd_bank  <= ~rd_bank;
                    rd_state <= full[~rd_bank] ? READ : IDLE;
                end else begin
                    rd_state <= READ;
                end
            end else begin
                rd_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Bench for bitrev_reorder (N=8): a reordering instance and a natural-order instance
// share one input stream; expected samples with their due cycle sit in queues.
module tb_bitrev_reorder;

    localparam int N = 8;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         idata_en = 1'b0;
    logic [W-1:0] idata_r = '0;
    logic [W-1:0] idata_i = '0;

    logic         odata_en, frame_err;
    logic [W-1:0] odata_r, odata_i;
    logic         nat_en, nat_err;
    logic [W-1:0] nat_r, nat_i;

    bitrev_reorder #(.N(N), .WIDTH(W), .BITREV_EN(1)) u_rev (
        .clock(clock), .reset(reset), .idata_en(idata_en), .idata_r(idata_r), .idata_i(idata_i),
        .odata_en(odata_en), .odata_r(odata_r), .odata_i(odata_i), .frame_err(frame_err)
    );

    bitrev_reorder #(.N(N), .WIDTH(W), .BITREV_EN(0)) u_nat (
        .clock(clock), .reset(reset), .idata_en(idata_en), .idata_r(idata_r), .idata_i(idata_i),
        .odata_en(nat_en), .odata_r(nat_r), .odata_i(nat_i), .frame_err(nat_err)
    );

    // clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state: entries are {due_cycle, real, imag}
    logic [63:0] exp_q[$];
    logic [63:0] exp_nat_q[$];
    int          err_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic [W-1:0] fr_r [N];
    logic [W-1:0] fr_i [N];
    int           fr_cnt = 0;
    int           fr_t0 = 0;
    logic         mon_on = 1'b0;
    logic [W-1:0] last_r = '0, last_i = '0, last_nr = '0, last_ni = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic int br3(input int j);
        logic [2:0] v;
        v = j[2:0];
        return int'({v[0], v[1], v[2]});
    endfunction

    // driver tasks
    task automatic drive_sample(input logic [W-1:0] r, input logic [W-1:0] i);
        @(posedge clock);
        #1;
        idata_en = 1'b1;
        idata_r  = r;
        idata_i  = i;
        if (fr_cnt == 0) fr_t0 = cyc;
        fr_r[fr_cnt] = r;
        fr_i[fr_cnt] = i;
        fr_cnt++;
        if (fr_cnt == N) begin
            for (int j = 0; j < N; j++) begin
                exp_q.push_back({32'(fr_t0 + N + 1 + j), fr_r[br3(j)], fr_i[br3(j)]});
                exp_nat_q.push_back({32'(fr_t0 + N + 1 + j), fr_r[j], fr_i[j]});
            end
            fr_cnt = 0;
        end
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            idata_en = 1'b0;
            idata_r  = W'($urandom);
            idata_i  = W'($urandom);
            if (fr_cnt != 0) begin
                err_q.push_back(cyc + 1);
                fr_cnt = 0;
            end
        end
    endtask

    // monitor: compare outputs on the falling edge
    logic [63:0] e;
    logic        exp_err;
    always @(negedge clock) begin
        if (mon_on && !reset) begin
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            check("rev_frame_err", 64'(frame_err), 64'(exp_err));
            check("nat_frame_err", 64'(nat_err), 64'(exp_err));

            if (odata_en) begin
                if (exp_q.size() == 0) begin
                    check("rev_unexpected_en", 64'(odata_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rev_out", {32'(cyc), odata_r, odata_i}, e);
                end
                last_r = odata_r;
                last_i = odata_i;
            end else begin
                check("rev_hold", {32'd0, odata_r, odata_i}, {32'd0, last_r, last_i});
            end

            if (nat_en) begin
                if (exp_nat_q.size() == 0) begin
                    check("nat_unexpected_en", 64'(nat_en), 64'd0);
                end else begin
                    e = exp_nat_q.pop_front();
                    check("nat_out", {32'(cyc), nat_r, nat_i}, e);
                end
                last_nr = nat_r;
                last_ni = nat_i;
            end else begin
                check("nat_hold", {32'd0, nat_r, nat_i}, {32'd0, last_nr, last_ni});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},  64'(odata_en), 64'd0);
        check({tag, "_r"},   64'(odata_r), 64'd0);
        check({tag, "_i"},   64'(odata_i), 64'd0);
        check({tag, "_err"}, 64'(frame_err), 64'd0);
        check({tag, "_nat_en"}, 64'(nat_en), 64'd0);
        check({tag, "_nat_ri"}, {32'd0, nat_r, nat_i}, 64'd0);
    endtask

    // stimulus
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset  = 1'b0;
        mon_on = 1'b1;
        drive_idle(3);

        // single frame r=k, i=-k
        for (int k = 0; k < N; k++) drive_sample(W'(k), W'(-k));
        drive_idle(20);

        // three back-to-back frames
        for (int k = 0; k < 3 * N; k++) drive_sample(W'(k), W'(k + 100));
        drive_idle(20);

        // truncated 5-sample frame, 3 idle, full frame
        for (int k = 0; k < 5; k++) drive_sample(W'(k + 50), W'(k + 60));
        drive_idle(3);
        for (int k = 0; k < N; k++) drive_sample(W'(k + 200), W'(k + 300));
        drive_idle(20);

        // frames separated by 4-cycle gaps
        repeat (3) begin
            for (int k = 0; k < N; k++) drive_sample(W'($urandom), W'($urandom));
            drive_idle(4);
        end
        drive_idle(20);

        // reset at output cycle 3 while the next frame is half-written
        for (int k = 0; k < N; k++) drive_sample(W'(k + 400), W'(k + 500));
        for (int k = 0; k < N / 2; k++) drive_sample(W'(k + 600), W'(k + 700));
        @(posedge clock);
        #1;
        check("rst_pre_en", 64'(odata_en), 64'd1);
        reset    = 1'b1;
        idata_en = 1'b0;
        exp_q.delete();
        exp_nat_q.delete();
        err_q.delete();
        fr_cnt  = 0;
        last_r  = '0;
        last_i  = '0;
        last_nr = '0;
        last_ni = '0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        drive_idle(2);
        for (int k = 0; k < N; k++) drive_sample(W'(k + 800), W'(k + 900));
        drive_idle(20);

        // random frame lengths and gaps
        repeat (10) begin
            int len;
            len = $urandom_range(1, N);
            for (int k = 0; k < len; k++) drive_sample(W'($urandom), W'($urandom));
            if ($urandom_range(0, 2) != 0) drive_idle($urandom_range(1, 4));
        end
        drive_idle(3);

        // drain with a bounded wait
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0 && exp_nat_q.size() == 0 && err_q.size() == 0) break;
            @(posedge clock);
        end
        drive_idle(2);
        check("drain_rev", 64'(exp_q.size()), 64'd0);
        check("drain_nat", 64'(exp_nat_q.size()), 64'd0);
        check("drain_err", 64'(err_q.size()), 64'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
